// File: rtl/bus_mux_driver.sv
// rtl/bus_mux_driver.sv - registered shared-bus source mux with contention logging
// Lowest set strobe wins; any multi-strobe cycle is flagged, latched and counted.
module bus_mux_driver #(
  parameter int DATA_WIDTH  = 32,
  parameter int NUM_SOURCES = 24,
  parameter int IDX_W       = 5,
  parameter int CNT_W       = 8
) (
  input  logic                              clock,
  input  logic                              clear,
  input  logic [NUM_SOURCES*DATA_WIDTH-1:0] src_data,
  input  logic [NUM_SOURCES-1:0]            src_out,
  input  logic                              err_ack,
  output logic [DATA_WIDTH-1:0]             BusMuxOut,
  output logic                              bus_valid,
  output logic [IDX_W-1:0]                  src_index,
  output logic                              conflict,
  output logic                              conflict_sticky,
  output logic [CNT_W-1:0]                  conflict_count
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic                  anyHit;
  logic                  multiHit;
  logic [IDX_W-1:0]      selIdx;
  logic [DATA_WIDTH-1:0] selWord;

  // Ascending scan so the first strobe seen is the lowest index.
  always_comb begin
    anyHit   = 1'b0;
    multiHit = 1'b0;
    selIdx   = '0;
    selWord  = '0;
    for (int i = 0; i < NUM_SOURCES; i++) begin
      if (src_out[i]) begin
        if (anyHit) begin
          multiHit = 1'b1;
        end else begin
          anyHit  = 1'b1;
          selIdx  = IDX_W'(i);
          selWord = src_data[i*DATA_WIDTH +: DATA_WIDTH];
        end
      end
    end
  end

  always_ff @(posedge clock) begin
    if (clear) begin
      BusMuxOut       <= '0;
      bus_valid       <= 1'b0;
      src_index       <= '0;
      conflict        <= 1'b0;
      conflict_sticky <= 1'b0;
      conflict_count  <= '0;
    end else begin
      bus_valid <= anyHit;
      conflict  <= multiHit;
      if (anyHit) begin
        BusMuxOut <= selWord;
        src_index <= selIdx;
      end
      // A conflict on the acknowledge edge restarts the log at one event.
      if (multiHit) begin
        conflict_sticky <= 1'b1;
        if (err_ack)
          conflict_count <= CNT_W'(1);
        else if (conflict_count != CNT_MAX)
          conflict_count <= conflict_count + 1'b1;
      end else if (err_ack) begin
        conflict_sticky <= 1'b0;
        conflict_count  <= '0;
      end
    end
  end

endmodule
